// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: FSM state encoding and the
// layout of a 2-bit program symbol (bit1 = level, bit0 = duration select).
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int SYM_BITS      = 2;
  localparam int SYM_LEVEL_BIT = 1;
  localparam int SYM_DUR_BIT   = 0;

endpackage

// File: rtl/pulse_seq_carrier.sv
// Carrier generator for high-level symbols. Built only when
// PULSE_SEQ_CARRIER_EN is defined. 'level' is the value pulse_out takes at
// the coming edge: a 50% square wave of period 2*(div+1) that restarts high
// whenever 'restart' marks the first cycle of a new symbol.
`ifdef PULSE_SEQ_CARRIER_EN
module pulse_seq_carrier (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [7:0] div,
  output logic       level
);

  logic [7:0] half_cnt;
  logic       phase;

  // Next carrier value: forced high on restart, otherwise toggles after div+1 cycles.
  always_comb begin
    level = phase;
    if (restart) begin
      level = 1'b1;
    end else if (half_cnt == div) begin
      level = ~phase;
    end
  end

  // Half-period counter and current carrier phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else if (restart) begin
      half_cnt <= '0;
      phase    <= 1'b1;
    end else if (half_cnt == div) begin
      half_cnt <= '0;
      phase    <= ~phase;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: plays a stored program of 2-bit symbols onto pulse_out.
// Each symbol holds its level for duration+1 cycles; words are prefetched
// during the last symbol of the current word so word boundaries are gapless.
// Optional carrier modulation is compiled in with PULSE_SEQ_CARRIER_EN.
// Handshake: start is a level sampled in IDLE (ignored while busy); stop
// aborts FETCH/PLAY on the next edge and wins over a coincident start.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int NUM_WORDS     = 8,
  parameter int SYMS_PER_WORD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [2:0]  last_word,
  input  logic [7:0]  loop_count,
  input  logic [7:0]  dur_short,
  input  logic [7:0]  dur_long,
  input  logic        idle_level,
`ifdef PULSE_SEQ_CARRIER_EN
  input  logic        carrier_en,
  input  logic [7:0]  carrier_div,
`endif
  output logic [2:0]  read_address,
  input  logic [31:0] data_in,
  output logic        pulse_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam int IDX_W = $clog2(SYMS_PER_WORD);

  seq_state_t state_q, state_d;

  logic [2:0]       last_word_q;
  logic [7:0]       loops_left;
  logic [7:0]       dur_short_q, dur_long_q;
  logic             idle_q;
  logic [31:0]      word_q;
  logic [IDX_W-1:0] sym_idx, sym_nxt;
  logic [7:0]       dur_cnt, next_dur;
  logic [2:0]       word_idx, next_word;
  logic             cur_level;

  logic             sym_end, last_sym, wrap, word_end, finish;
  logic             sym_start, load_word;
  logic [1:0]       next_sym;
  logic             play_level, drive_level;

  // Symbol/word sequencing conditions derived from the counters.
  always_comb begin
    sym_nxt    = sym_idx + 1'b1;
    sym_end    = (dur_cnt == 8'd0);
    last_sym   = (sym_idx == IDX_W'(SYMS_PER_WORD - 1));
    wrap       = (word_idx == last_word_q) || (word_idx == 3'(NUM_WORDS - 1));
    next_word  = wrap ? 3'd0 : word_idx + 3'd1;
    word_end   = (state_q == ST_PLAY) && sym_end && last_sym;
    finish     = word_end && wrap && (loops_left == 8'd0);
    load_word  = (state_q == ST_FETCH) || word_end;
    sym_start  = !stop && ((state_q == ST_FETCH) ||
                           ((state_q == ST_PLAY) && sym_end && !finish));
    next_sym   = load_word ? data_in[SYM_BITS-1:0]
                           : word_q[SYM_BITS*sym_nxt +: SYM_BITS];
    next_dur   = next_sym[SYM_DUR_BIT] ? dur_long_q : dur_short_q;
    play_level = sym_start ? next_sym[SYM_LEVEL_BIT] : cur_level;
  end

`ifdef PULSE_SEQ_CARRIER_EN
  logic carrier_level;

  pulse_seq_carrier u_carrier (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (sym_start),
    .div     (carrier_div),
    .level   (carrier_level)
  );

  assign drive_level = play_level & (carrier_level | ~carrier_en);
`else
  assign drive_level = play_level;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop aborts any active phase and beats a same-cycle start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_FETCH;
      ST_FETCH: state_d = stop ? ST_IDLE : ST_PLAY;
      ST_PLAY: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (finish) begin
          state_d = ST_DONE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs; the address runs one word ahead during a word's last symbol.
  always_comb begin
    busy         = (state_q == ST_FETCH) || (state_q == ST_PLAY);
    done         = (state_q == ST_DONE);
    state_dbg    = state_q;
    read_address = 3'd0;
    if (state_q == ST_PLAY) begin
      read_address = last_sym ? next_word : word_idx;
    end else if (state_q == ST_FETCH) begin
      read_address = word_idx;
    end
  end

  // Configuration latch, symbol counters and the registered pulse stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word_q <= '0;
      loops_left  <= '0;
      dur_short_q <= '0;
      dur_long_q  <= '0;
      idle_q      <= 1'b0;
      word_q      <= '0;
      sym_idx     <= '0;
      dur_cnt     <= '0;
      word_idx    <= '0;
      cur_level   <= 1'b0;
      pulse_out   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            last_word_q <= last_word;
            loops_left  <= loop_count;
            dur_short_q <= dur_short;
            dur_long_q  <= dur_long;
            idle_q      <= idle_level;
            word_idx    <= '0;
            pulse_out   <= idle_level;
          end
        end
        ST_FETCH, ST_PLAY: begin
          if (stop || finish) begin
            pulse_out <= idle_q;
            word_idx  <= '0;
          end else begin
            pulse_out <= drive_level;
            if (sym_start) begin
              sym_idx   <= load_word ? '0 : sym_nxt;
              dur_cnt   <= next_dur;
              cur_level <= next_sym[SYM_LEVEL_BIT];
              if (load_word) word_q <= data_in;
              if (word_end) begin
                word_idx <= next_word;
                if (wrap && (loops_left != 8'd0)) loops_left <= loops_left - 8'd1;
              end
            end else begin
              dur_cnt <= dur_cnt - 8'd1;
            end
          end
        end
        default: pulse_out <= idle_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: a program-level model expands stored words into
// a per-cycle expectation queue, and a negedge compare process checks
// pulse_out/busy/done/read_address against it.
module tb_pulse_sequencer;
  import pulse_seq_pkg::*;

  localparam int SYMS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [2:0]  last_word;
  logic [7:0]  loop_count, dur_short, dur_long;
  logic        idle_level;
  logic        carrier_en;
  logic [7:0]  carrier_div;
  logic [2:0]  read_address;
  logic [31:0] data_in;
  logic        pulse_out, busy, done;
  logic [1:0]  state_dbg;

  logic [31:0] mem [8];

  // expectation word: {pulse, busy, done, addr_chk, addr[2:0]}
  logic [6:0] exp_q[$];
  logic [6:0] e;
  bit         checking = 1'b0;
  int         total  = 0;
  int         passed = 0;

  assign data_in = mem[read_address];

  pulse_sequencer #(.NUM_WORDS(8), .SYMS_PER_WORD(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .last_word    (last_word),
    .loop_count   (loop_count),
    .dur_short    (dur_short),
    .dur_long     (dur_long),
    .idle_level   (idle_level),
`ifdef PULSE_SEQ_CARRIER_EN
    .carrier_en   (carrier_en),
    .carrier_div  (carrier_div),
`endif
    .read_address (read_address),
    .data_in      (data_in),
    .pulse_out    (pulse_out),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // model: expand the program into expected per-cycle outputs
  task automatic build_exp(input logic idle, input logic [2:0] lw, input logic [7:0] lc,
                           input logic [7:0] ds, input logic [7:0] dl);
    logic [1:0] sym;
    int         dur, nxt;
    logic       lvl;
    exp_q.delete();
    exp_q.push_back({idle, 1'b1, 1'b0, 1'b1, 3'd0});              // FETCH cycle
    for (int l = 0; l <= int'(lc); l++)
      for (int w = 0; w <= int'(lw); w++)
        for (int s = 0; s < SYMS; s++) begin
          sym = 2'(mem[w] >> (2 * s));
          dur = sym[0] ? int'(dl) : int'(ds);
          nxt = (w == int'(lw)) ? 0 : w + 1;
          for (int k = 0; k <= dur; k++) begin
            lvl = sym[1];
            if (carrier_en && lvl) lvl = ((k / (int'(carrier_div) + 1)) % 2) == 0;
            exp_q.push_back({lvl, 1'b1, 1'b0, 1'b1, 3'((s == SYMS - 1) ? nxt : w)});
          end
        end
    exp_q.push_back({idle, 1'b0, 1'b1, 1'b0, 3'd0});              // DONE strobe
    exp_q.push_back({idle, 1'b0, 1'b0, 1'b0, 3'd0});              // back in IDLE
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    if (checking && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pulse_out", 32'(pulse_out), 32'(e[6]));
      check("busy",      32'(busy),      32'(e[5]));
      check("done",      32'(done),      32'(e[4]));
      if (e[3]) check("read_address", 32'(read_address), 32'(e[2:0]));
      if (exp_q.size() == 0) checking = 1'b0;
    end
  end

  // driver: pulse start with a configuration, then scramble the inputs
  task automatic launch(input logic idle, input logic [2:0] lw, input logic [7:0] lc,
                        input logic [7:0] ds, input logic [7:0] dl);
    @(posedge clk); #1;
    idle_level = idle; last_word = lw; loop_count = lc;
    dur_short = ds; dur_long = dl; start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    checking   = 1'b1;
    idle_level = 1'($urandom_range(0, 1));
    last_word  = 3'($urandom_range(0, 7));
    loop_count = 8'($urandom_range(0, 255));
    dur_short  = 8'($urandom_range(0, 255));
    dur_long   = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      checking = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    last_word = '0; loop_count = '0; dur_short = '0; dur_long = '0;
    idle_level = 1'b0; carrier_en = 1'b0; carrier_div = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // reset state
    #12;
    check("rst_pulse_out", 32'(pulse_out), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_raddr",     32'(read_address), 32'd0);
    check("rst_state",     32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk); #1 rst_n = 1'b1;

    // single word: high 3 cycles, low 15, then done
    mem[0] = 32'h0000_0003;
    build_exp(1'b0, 3'd0, 8'd0, 8'd0, 8'd2);
    check("model_len_single", 32'(exp_q.size()), 32'd21);
    check("model_first_hi",   32'(exp_q[1][6]),  32'd1);
    check("model_third_hi",   32'(exp_q[3][6]),  32'd1);
    check("model_fourth_lo",  32'(exp_q[4][6]),  32'd0);
    check("model_done_slot",  32'(exp_q[19][5:4]), 32'd1);
    launch(1'b0, 3'd0, 8'd0, 8'd0, 8'd2);
    wait_drain();

    // two words, two extra loops, all durations 0, idle high
    mem[0] = 32'h9C3A_65F1; mem[1] = 32'h0F0F_A5C3;
    build_exp(1'b1, 3'd1, 8'd2, 8'd0, 8'd0);
    check("model_len_loop", 32'(exp_q.size()), 32'd99);
    check("model_addr_pref", 32'(exp_q[16][2:0]), 32'd1);
    check("model_addr_wrap", 32'(exp_q[32][2:0]), 32'd0);
    launch(1'b1, 3'd1, 8'd2, 8'd0, 8'd0);
    wait_drain();

    // mixed symbols and durations over three words
    mem[0] = 32'h1B4E_72D9; mem[1] = 32'hC3A5_0F96; mem[2] = 32'h6D2B_E184;
    build_exp(1'b1, 3'd2, 8'd1, 8'd1, 8'd3);
    launch(1'b1, 3'd2, 8'd1, 8'd1, 8'd3);
    wait_drain();

    // longest duration
    mem[0] = 32'h0000_0003;
    build_exp(1'b0, 3'd0, 8'd0, 8'd0, 8'd255);
    check("model_len_long", 32'(exp_q.size()), 32'd274);
    launch(1'b0, 3'd0, 8'd0, 8'd0, 8'd255);
    wait_drain();

    // start pulsed during PLAY must not restart or re-latch
    mem[0] = 32'h1B4E_72D9; mem[1] = 32'hC3A5_0F96;
    build_exp(1'b0, 3'd1, 8'd0, 8'd1, 8'd2);
    launch(1'b0, 3'd1, 8'd0, 8'd1, 8'd2);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; dur_short = 8'd9; dur_long = 8'd9;
    @(posedge clk); #1 start = 1'b0;
    wait_drain();

    // stop during PLAY cycle 5: idle next edge, no done
    mem[0] = 32'hFFFF_FFFF;
    build_exp(1'b0, 3'd0, 8'd0, 8'd0, 8'd0);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    repeat (4) exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    launch(1'b0, 3'd0, 8'd0, 8'd0, 8'd0);
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_drain();

    // start and stop together in IDLE: nothing begins
    @(posedge clk); #1 start = 1'b1; stop = 1'b1; idle_level = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ss_busy",  32'(busy),      32'd0);
      check("ss_state", 32'(state_dbg), 32'(ST_IDLE));
      check("ss_pulse", 32'(pulse_out), 32'd0);
    end

    // asynchronous reset in the middle of PLAY
    mem[0] = 32'h0000_0000; mem[1] = 32'hFFFF_FFFF;
    build_exp(1'b0, 3'd1, 8'd0, 8'd0, 8'd3);
    launch(1'b0, 3'd1, 8'd0, 8'd0, 8'd3);
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_pulse", 32'(pulse_out), 32'd1);
    check("pre_rst_raddr", 32'(read_address), 32'd1);
    #1;
    checking = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("arst_pulse", 32'(pulse_out), 32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_done",  32'(done),      32'd0);
    check("arst_raddr", 32'(read_address), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

`ifdef PULSE_SEQ_CARRIER_EN
    // carrier div 1 on a high symbol of duration 7 -> 11001100
    mem[0] = 32'h0000_0003;
    carrier_en = 1'b1; carrier_div = 8'd1;
    build_exp(1'b0, 3'd0, 8'd0, 8'd0, 8'd7);
    for (int i = 0; i < 8; i++)
      check("model_carrier", 32'(exp_q[1 + i][6]), 32'(((i / 2) % 2) == 0));
    launch(1'b0, 3'd0, 8'd0, 8'd0, 8'd7);
    wait_drain();
    carrier_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
